// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, CTRL fields, modes and FSM states for timer_device
package timer_pkg;

  localparam logic [1:0] OFF_CTRL     = 2'd0;
  localparam logic [1:0] OFF_PRESET   = 2'd1;
  localparam logic [1:0] OFF_COUNT    = 2'd2;
  localparam logic [1:0] OFF_PRESCALE = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  // Reserved mode encodings fold onto one-shot.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == MODE_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_if.sv
// rtl/timer_if.sv - bridge-to-peripheral bus: address, write data/strobe, read data and IRQ
interface timer_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        IRQ;

  modport master (output addr, output we, output din, input dout, input IRQ);
  modport slave  (input addr, input we, input din, output dout, output IRQ);
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - enable-tick generator; tick is high whenever the down-counter is zero
module timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] prescale,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - W'(1);
    if (load || tick) cnt_d = prescale;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_device.sv
// rtl/timer_device.sv - memory-mapped countdown timer (one-shot/periodic) with masked IRQ
// TIMER_PRESCALE_EN adds a PRESCALE register at offset 3 gating each decrement.
module timer_device
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic   clk,
  input  logic   reset,
  timer_if.slave bus
);

  logic [3:0]            ctrl_q, ctrl_d;
  logic [31:0]           preset_q, preset_d;
  logic [31:0]           count_q, count_d;
  state_t                state_q, state_d;
  logic                  irq_flag_q, irq_flag_d;
  logic [PRESCALE_W-1:0] prescale_val;
  logic                  tick;
  logic [1:0]            reg_sel;
  logic [1:0]            mode;
  logic                  unused_addr;

  assign reg_sel     = bus.addr[3:2];
  assign mode        = eff_mode(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);
  assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == S_LOAD),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_comb begin
    prescale_d = prescale_q;
    if (bus.we && reg_sel == OFF_PRESCALE) prescale_d = bus.din[PRESCALE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) prescale_q <= '0;
    else       prescale_q <= prescale_d;
  end

  assign prescale_val = prescale_q;
`else
  assign tick         = 1'b1;
  assign prescale_val = '0;
`endif

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      S_IDLE: if (ctrl_q[CTRL_EN]) state_d = S_LOAD;
      S_LOAD: begin
        count_d    = preset_q;
        irq_flag_d = 1'b0;
        state_d    = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = S_IDLE;
        end else if (tick) begin
          // PRESET 0 lands here on the first tick, so it expires like PRESET 1.
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = 32'd0;
            irq_flag_d = 1'b1;
            state_d    = S_INT;
          end
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        if (mode == MODE_PERIODIC) irq_flag_d = 1'b0;
        else                       ctrl_d[CTRL_EN] = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Software writes come last so they override the FSM's own CTRL update.
    if (bus.we) begin
      case (reg_sel)
        OFF_CTRL: begin
          ctrl_d = bus.din[3:0];
          if (mode == MODE_ONESHOT) irq_flag_d = 1'b0;
        end
        OFF_PRESET: preset_d = bus.din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    bus.dout = '0;
    case (reg_sel)
      OFF_CTRL:   bus.dout = {28'd0, ctrl_q};
      OFF_PRESET: bus.dout = preset_q;
      OFF_COUNT:  bus.dout = count_q;
      default:    bus.dout = 32'(prescale_val);
    endcase
  end

  assign bus.IRQ = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule
